xm_mem_interface: RTL and testbench

Memory access unit sitting directly downstream of the multi-cycle controller/datapath. It accepts one byte or word request at a time and produces the `memBusy` handshake the controller waits on in its DECODE, MEM_CONFIRM and MEM_WRITEBACK states. It drives a 16-bit little-endian external memory port with byte enables, inserts programmable wait states and honours an external ready. It returns read data with byte extraction and flags misaligned word accesses and ready timeouts.

---
 rtl/xm_mem_interface_if.sv | 32 +++
 rtl/xm_mem_interface.sv | 163 ++++++++++++++++
 tb/tb_xm_mem_interface.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/xm_mem_interface_if.sv
// Bus bundle between the controller, xm_mem_interface and the external 16-bit memory.
// The master modport is the side that drives requests and also models the memory.
interface xm_mem_interface_if #(parameter int WORD = 16);
    logic            memEn_i;
    logic            memRW_i;
    logic            byteOp_i;
    logic [WORD-1:0] adr_i;
    logic [WORD-1:0] wdata_i;
    logic            memBusy_o;
    logic [WORD-1:0] rdata_o;
    logic            fault_o;
    logic [1:0]      faultCode_o;
    logic            ext_cs_o;
    logic            ext_we_o;
    logic [1:0]      ext_be_o;
    logic [WORD-2:0] ext_adr_o;
    logic [WORD-1:0] ext_wdata_o;
    logic [WORD-1:0] ext_rdata_i;
    logic            ext_rdy_i;

    modport slave (
        input  memEn_i, memRW_i, byteOp_i, adr_i, wdata_i, ext_rdata_i, ext_rdy_i,
        output memBusy_o, rdata_o, fault_o, faultCode_o,
               ext_cs_o, ext_we_o, ext_be_o, ext_adr_o, ext_wdata_o
    );

    modport master (
        output memEn_i, memRW_i, byteOp_i, adr_i, wdata_i, ext_rdata_i, ext_rdy_i,
        input  memBusy_o, rdata_o, fault_o, faultCode_o,
               ext_cs_o, ext_we_o, ext_be_o, ext_adr_o, ext_wdata_o
    );
endinterface

// File: rtl/xm_mem_interface.sv
// Single-request memory access unit: byte/word accesses to a 16-bit little-endian
// port with wait states, external ready, misalignment and timeout faults.
module xm_mem_interface #(
    parameter int WORD        = 16,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    xm_mem_interface_if.slave       bus,
    output logic [1:0]              dbg_state_o
);

    // Handshake: a request is taken when memEn_i is high at a posedge in IDLE;
    // memBusy_o stays high until the completion/abort edge, and memEn_i is
    // ignored while busy and on the completion edge itself (no queueing).
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, FAULT = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic [7:0]      to_q, to_d;
    logic            rw_q, rw_d;
    logic            byte_q, byte_d;
    logic            odd_q, odd_d;
    logic            busy_q, busy_d;
    logic [WORD-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;
    logic [1:0]      code_q, code_d;
    logic            cs_q, cs_d;
    logic            we_q, we_d;
    logic [1:0]      be_q, be_d;
    logic [WORD-2:0] adr_q, adr_d;
    logic [WORD-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        to_d    = to_q;
        rw_d    = rw_q;
        byte_d  = byte_q;
        odd_d   = odd_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        code_d  = code_q;
        cs_d    = cs_q;
        we_d    = we_q;
        be_d    = be_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.memEn_i) begin
                    rw_d   = bus.memRW_i;
                    byte_d = bus.byteOp_i;
                    odd_d  = bus.adr_i[0];
                    busy_d = 1'b1;
                    if (!bus.byteOp_i && bus.adr_i[0]) begin
                        state_d = FAULT;
                    end else begin
                        state_d = ACCESS;
                        cs_d    = 1'b1;
                        we_d    = bus.memRW_i;
                        wait_d  = 4'(WAIT_STATES);
                        to_d    = 8'(TIMEOUT);
                        code_d  = 2'b00;
                        adr_d   = bus.adr_i[WORD-1:1];
                        if (bus.byteOp_i) begin
                            be_d    = bus.adr_i[0] ? 2'b10 : 2'b01;
                            wdata_d = {(WORD/8){bus.wdata_i[7:0]}};
                        end else begin
                            be_d    = 2'b11;
                            wdata_d = bus.wdata_i;
                        end
                    end
                end
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (bus.ext_rdy_i) begin
                    if (!rw_q) begin
                        if (byte_q)
                            rdata_d = {{(WORD-8){1'b0}},
                                       odd_q ? bus.ext_rdata_i[15:8] : bus.ext_rdata_i[7:0]};
                        else
                            rdata_d = bus.ext_rdata_i;
                    end
                    busy_d  = 1'b0;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Abort on the edge where the timeout counter reaches zero.
                    to_d = to_q - 8'd1;
                    if (to_q == 8'd1) begin
                        fault_d = 1'b1;
                        code_d  = 2'b10;
                        busy_d  = 1'b0;
                        cs_d    = 1'b0;
                        we_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            FAULT: begin
                fault_d = 1'b1;
                code_d  = 2'b01;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            to_q    <= '0;
            rw_q    <= 1'b0;
            byte_q  <= 1'b0;
            odd_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            rw_q    <= rw_d;
            byte_q  <= byte_d;
            odd_q   <= odd_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            be_q    <= be_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.memBusy_o   = busy_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.fault_o     = fault_q;
    assign bus.faultCode_o = code_q;
    assign bus.ext_cs_o    = cs_q;
    assign bus.ext_we_o    = we_q;
    assign bus.ext_be_o    = be_q;
    assign bus.ext_adr_o   = adr_q;
    assign bus.ext_wdata_o = wdata_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_xm_mem_interface.sv
// Directed bench for xm_mem_interface with WAIT_STATES = 1 and TIMEOUT = 4; inputs
// change and outputs are sampled on negedge, as the controller does.
module tb_xm_mem_interface;
    localparam int WORD = 16;
    localparam int WS   = 1;
    localparam int TO   = 4;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic [1:0] dbg_state;

    xm_mem_interface_if #(.WORD(WORD)) bus ();

    xm_mem_interface #(.WORD(WORD), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .arst_i      (arst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int              n_vec  = 0;
    int              n_fail = 0;
    logic [WORD-1:0] exp_q[$];

    int          cyc;
    logic        cs_any;
    logic [15:0] s_adr, s_be, s_wd, s_we;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge, snapshot the external port after
    // acceptance, then count busy cycles until memBusy_o drops (bounded).
    task automatic run(input logic rw, input logic bt, input logic [15:0] adr,
                       input logic [15:0] wd);
        bus.memEn_i  = 1'b1;
        bus.memRW_i  = rw;
        bus.byteOp_i = bt;
        bus.adr_i    = adr;
        bus.wdata_i  = wd;
        @(negedge clk);
        bus.memEn_i = 1'b0;
        s_adr  = 16'(bus.ext_adr_o);
        s_be   = 16'(bus.ext_be_o);
        s_wd   = bus.ext_wdata_o;
        s_we   = 16'(bus.ext_we_o);
        cyc    = 0;
        cs_any = 1'b0;
        while (bus.memBusy_o && cyc < 64) begin
            cyc++;
            cs_any = cs_any | bus.ext_cs_o;
            @(negedge clk);
        end
        cs_any = cs_any | bus.ext_cs_o;
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_busy"},  16'(bus.memBusy_o),   16'h0);
        chk({pfx, "_rdata"}, bus.rdata_o,          16'h0);
        chk({pfx, "_fault"}, 16'(bus.fault_o),     16'h0);
        chk({pfx, "_code"},  16'(bus.faultCode_o), 16'h0);
        chk({pfx, "_cs"},    16'(bus.ext_cs_o),    16'h0);
        chk({pfx, "_we"},    16'(bus.ext_we_o),    16'h0);
        chk({pfx, "_be"},    16'(bus.ext_be_o),    16'h0);
        chk({pfx, "_adr"},   16'(bus.ext_adr_o),   16'h0);
        chk({pfx, "_wdata"}, bus.ext_wdata_o,      16'h0);
        chk({pfx, "_state"}, 16'(dbg_state),       16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.memEn_i     = 1'b0;
        bus.memRW_i     = 1'b0;
        bus.byteOp_i    = 1'b0;
        bus.adr_i       = '0;
        bus.wdata_i     = '0;
        bus.ext_rdata_i = '0;
        bus.ext_rdy_i   = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        arst_n = 1'b1;
        @(negedge clk);

        // Word read, one wait state
        bus.ext_rdata_i = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        run(1'b0, 1'b0, 16'h0100, 16'h0000);
        chk("wrd_adr",   s_adr, 16'h0080);
        chk("wrd_be",    s_be, 16'h0003);
        chk("wrd_we",    s_we, 16'h0000);
        chk("wrd_busy",  16'(cyc), 16'd2);
        chk("wrd_rdata", bus.rdata_o, exp_q.pop_front());
        chk("wrd_cs",    16'(bus.ext_cs_o), 16'h0);
        chk("wrd_fault", 16'(bus.fault_o), 16'h0);

        // Odd byte read selects the high lane
        bus.ext_rdata_i = 16'hA55A;
        exp_q.push_back(16'h00A5);
        run(1'b0, 1'b1, 16'h0101, 16'h0000);
        chk("obr_be",    s_be, 16'h0002);
        chk("obr_busy",  16'(cyc), 16'd2);
        chk("obr_rdata", bus.rdata_o, exp_q.pop_front());

        // Top byte address
        bus.ext_rdata_i = 16'h3C00;
        exp_q.push_back(16'h003C);
        run(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        chk("top_adr",   s_adr, 16'h7FFF);
        chk("top_be",    s_be, 16'h0002);
        chk("top_rdata", bus.rdata_o, exp_q.pop_front());

        // Even byte write replicates the low byte
        bus.ext_rdata_i = 16'hDEAD;
        run(1'b1, 1'b1, 16'h0200, 16'h1234);
        chk("ebw_we",    s_we, 16'h0001);
        chk("ebw_be",    s_be, 16'h0001);
        chk("ebw_wdata", s_wd, 16'h3434);
        chk("ebw_adr",   s_adr, 16'h0100);
        chk("ebw_busy",  16'(cyc), 16'd2);
        chk("ebw_rdata", bus.rdata_o, 16'h003C);

        // Misaligned word access
        run(1'b0, 1'b0, 16'h0003, 16'h0000);
        chk("mis_busy",  16'(cyc), 16'd1);
        chk("mis_cs",    16'(cs_any), 16'h0);
        chk("mis_fault", 16'(bus.fault_o), 16'h1);
        chk("mis_code",  16'(bus.faultCode_o), 16'h1);
        @(negedge clk);
        chk("mis_pulse", 16'(bus.fault_o), 16'h0);
        chk("mis_hold",  16'(bus.faultCode_o), 16'h1);

        // Timeout: abort at N+1+WS+TO-1, busy for 1+WS+TO-1 cycles
        bus.ext_rdy_i   = 1'b0;
        bus.ext_rdata_i = 16'h1111;
        run(1'b0, 1'b0, 16'h0010, 16'h0000);
        chk("to_busy",  16'(cyc), 16'd5);
        chk("to_fault", 16'(bus.fault_o), 16'h1);
        chk("to_code",  16'(bus.faultCode_o), 16'h2);
        chk("to_rdata", bus.rdata_o, 16'h003C);
        chk("to_cs",    16'(bus.ext_cs_o), 16'h0);
        @(negedge clk);
        chk("to_pulse", 16'(bus.fault_o), 16'h0);

        // A good read clears the fault code
        bus.ext_rdy_i   = 1'b1;
        bus.ext_rdata_i = 16'h5678;
        exp_q.push_back(16'h5678);
        run(1'b0, 1'b0, 16'h0020, 16'h0000);
        chk("clr_code",  16'(bus.faultCode_o), 16'h0);
        chk("clr_rdata", bus.rdata_o, exp_q.pop_front());
        chk("clr_fault", 16'(bus.fault_o), 16'h0);

        // memEn_i held through a stalled access
        bus.ext_rdy_i   = 1'b0;
        bus.ext_rdata_i = 16'h9ABC;
        bus.memEn_i     = 1'b1;
        bus.memRW_i     = 1'b0;
        bus.byteOp_i    = 1'b0;
        bus.adr_i       = 16'h0040;
        @(negedge clk);
        chk("st_busy_a", 16'(bus.memBusy_o), 16'h1);
        @(negedge clk);
        chk("st_busy_b", 16'(bus.memBusy_o), 16'h1);
        @(negedge clk);
        chk("st_busy_c", 16'(bus.memBusy_o), 16'h1);
        chk("st_cs_c",   16'(bus.ext_cs_o), 16'h1);
        bus.ext_rdy_i = 1'b1;
        @(negedge clk);
        chk("st_done_busy", 16'(bus.memBusy_o), 16'h0);
        chk("st_done_cs",   16'(bus.ext_cs_o), 16'h0);
        chk("st_rdata",     bus.rdata_o, 16'h9ABC);
        @(negedge clk);
        chk("st_next_busy",  16'(bus.memBusy_o), 16'h1);
        chk("st_next_cs",    16'(bus.ext_cs_o), 16'h1);
        chk("st_next_state", 16'(dbg_state), 16'h1);
        bus.memEn_i = 1'b0;

        // Reset in the middle of ACCESS, away from any posedge
        #2 arst_n = 1'b0;
        #1 chk_reset_values("mid");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_busy",  16'(bus.memBusy_o), 16'h0);
        chk("post_state", 16'(dbg_state), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
